// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator.
//   mode_t       : test-pattern selector carried on the 2-bit mode input
//   DEF_*        : default 640x480@60 timing and datapath widths
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GRID    = 2'd3
  } mode_t;

  // 640x480@60 with a 25.175 MHz pixel clock
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 1;
  localparam int DEF_CNT_W     = 10;
  localparam int DEF_COLOR_W   = 3;
  localparam int DEF_BAR_COUNT = 8;

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern source.
//   x, y        : pixel coordinates being rendered
//   mode        : pattern for this frame
//   solid_color : colour for solid mode
//   bar_color   : colour-bar index (already truncated to COLOR_W)
//   color       : pattern colour (blanking is applied by the caller)
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic [CNT_W-1:0]   x,
  input  logic [CNT_W-1:0]   y,
  input  mode_t              mode,
  input  logic [COLOR_W-1:0] solid_color,
  input  logic [COLOR_W-1:0] bar_color,
  output logic [COLOR_W-1:0] color
);

  logic               checker_bit;
  logic               grid_bit;
  logic [COLOR_W-1:0] checker_color;
  logic [COLOR_W-1:0] grid_color;

  // 32x32 checkerboard and a 32-pixel grid closed on the right/bottom edge
  assign checker_bit = x[5] ^ y[5];
  assign grid_bit    = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) ||
                       (x == CNT_W'(H_ACTIVE - 1)) || (y == CNT_W'(V_ACTIVE - 1));

  generate
    for (genvar gi = 0; gi < COLOR_W; gi++) begin : g_fan
      assign checker_color[gi] = checker_bit;
      assign grid_color[gi]    = grid_bit;
    end
  endgenerate

  always_comb begin
    color = '0;
    case (mode)
      MODE_BARS:    color = bar_color;
      MODE_SOLID:   color = solid_color;
      MODE_CHECKER: color = checker_color;
      MODE_GRID:    color = grid_color;
      default:      color = '0;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with built-in test patterns.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : generator enable; low holds the raster at (0,0)
//   mode        : pattern select, latched at the start of each frame
//   solid_color : colour for solid mode (used live, not latched)
//   hsync/vsync : sync outputs, polarity set by HS_POL/VS_POL
//   active      : pixel is in the visible area
//   pix_x/pix_y : coordinates of the pixel currently on the outputs
//   line_start  : one-clk pulse with pixel x=0
//   frame_start : one-clk pulse with pixel (0,0)
//   color       : pixel colour, 0 during blanking
// All outputs are registered from the pre-advance counters on each pixel
// tick, so they are mutually aligned with one tick of latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int BAR_COUNT = DEF_BAR_COUNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] solid_color,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] color
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / BAR_COUNT;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_POS_LAST = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] BAR_IDX_LAST = CNT_W'(BAR_COUNT - 1);

  // raster state
  logic [DIV_W-1:0]   div_reg;
  logic [CNT_W-1:0]   h_reg, v_reg;
  logic [CNT_W-1:0]   h_next, v_next;
  logic [CNT_W-1:0]   bar_idx_reg, bar_pos_reg;
  logic [CNT_W-1:0]   bar_idx_cur, bar_pos_cur;
  logic [CNT_W-1:0]   bar_idx_next, bar_pos_next;
  mode_t              mode_q_reg;
  mode_t              mode_eff;

  // output registers
  logic               hsync_reg, vsync_reg, active_reg;
  logic               line_start_reg, frame_start_reg;
  logic [CNT_W-1:0]   pix_x_reg, pix_y_reg;
  logic [COLOR_W-1:0] color_reg;

  logic               tick;
  logic               h_wrap;
  logic               at_line_start;
  logic               at_frame_start;
  logic               hsync_next, vsync_next, active_next;
  logic [COLOR_W-1:0] pat_color;
  logic [COLOR_W-1:0] color_next;

  assign tick           = (div_reg == DIV_LAST);
  assign h_wrap         = (h_reg == H_LAST);
  assign at_line_start  = (h_reg == '0);
  assign at_frame_start = at_line_start && (v_reg == '0);

  assign h_next = h_wrap ? '0 : h_reg + CNT_W'(1);
  assign v_next = h_wrap ? ((v_reg == V_LAST) ? '0 : v_reg + CNT_W'(1)) : v_reg;

  // Running bar column: pos counts pixels inside the current bar, idx
  // steps at each bar boundary and sticks on the last bar, which then
  // absorbs the H_ACTIVE remainder. Both restart at h=0, so whatever
  // they held from the previous line's blanking is ignored.
  assign bar_idx_cur = at_line_start ? '0 : bar_idx_reg;
  assign bar_pos_cur = at_line_start ? '0 : bar_pos_reg;

  always_comb begin
    bar_idx_next = bar_idx_cur;
    bar_pos_next = bar_pos_cur + CNT_W'(1);
    if ((bar_pos_cur == BAR_POS_LAST) && (bar_idx_cur != BAR_IDX_LAST)) begin
      bar_idx_next = bar_idx_cur + CNT_W'(1);
      bar_pos_next = '0;
    end
  end

  // Pixel (0,0) is rendered in the same tick that latches mode, so it
  // already uses the incoming mode rather than the previous frame's.
  assign mode_eff = at_frame_start ? mode_t'(mode) : mode_q_reg;

  vga_pattern_gen #(
    .CNT_W    (CNT_W),
    .COLOR_W  (COLOR_W),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .x           (h_reg),
    .y           (v_reg),
    .mode        (mode_eff),
    .solid_color (solid_color),
    .bar_color   (bar_idx_cur[COLOR_W-1:0]),
    .color       (pat_color)
  );

  assign active_next = (h_reg < CNT_W'(H_ACTIVE)) && (v_reg < CNT_W'(V_ACTIVE));
  assign hsync_next  = ((h_reg >= HS_BEG) && (h_reg < HS_END)) ? HS_POL : ~HS_POL;
  assign vsync_next  = ((v_reg >= VS_BEG) && (v_reg < VS_END)) ? VS_POL : ~VS_POL;
  assign color_next  = active_next ? pat_color : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg         <= '0;
      h_reg           <= '0;
      v_reg           <= '0;
      bar_idx_reg     <= '0;
      bar_pos_reg     <= '0;
      mode_q_reg      <= MODE_BARS;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      color_reg       <= '0;
    end else if (!en) begin
      // hold the raster at (0,0) so enabling restarts a clean frame
      div_reg         <= '0;
      h_reg           <= '0;
      v_reg           <= '0;
      bar_idx_reg     <= '0;
      bar_pos_reg     <= '0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      color_reg       <= '0;
    end else begin
      div_reg         <= tick ? '0 : div_reg + DIV_W'(1);
      // strobes last only for the tick cycle itself
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      if (tick) begin
        h_reg           <= h_next;
        v_reg           <= v_next;
        bar_idx_reg     <= bar_idx_next;
        bar_pos_reg     <= bar_pos_next;
        if (at_frame_start) begin
          mode_q_reg <= mode_t'(mode);
        end
        hsync_reg       <= hsync_next;
        vsync_reg       <= vsync_next;
        active_reg      <= active_next;
        line_start_reg  <= at_line_start;
        frame_start_reg <= at_frame_start;
        pix_x_reg       <= h_reg;
        pix_y_reg       <= v_reg;
        color_reg       <= color_next;
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign active      = active_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign color       = color_reg;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with a built-in multi-mode test-pattern source.
- Produces hsync/vsync, an active-video flag, pixel coordinates, line/frame strobes and a COLOR_W-bit pixel colour.
- Timing, sync polarity and pixel-clock divide are set by parameters.
- Sits between the system clock and the VGA pins; later feeds the game renderer, which will replace the pattern source.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
CLK_DIV, 1, clk cycles per pixel (>=1)
CNT_W, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
COLOR_W, 3, colour bits
BAR_COUNT, 8, number of colour bars in bar mode

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  generator enable
mode  in  2  pattern select, sampled at frame start
solid_color  in  COLOR_W  colour used in solid mode
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  high while the pixel is in the visible area
pix_x  out  CNT_W  horizontal position of the current output pixel
pix_y  out  CNT_W  vertical position of the current output pixel
line_start  out  1  one-clk pulse with pixel h=0
frame_start  out  1  one-clk pulse with pixel (0,0)
color  out  COLOR_W  pixel colour; 0 outside the active area

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick fires when the divider equals CLK_DIV-1.
  - With CLK_DIV=1, every cycle is a tick.
- Counters, advancing on tick only:
  - h runs 0..H_TOTAL-1 and wraps to 0.
  - v increments only when h wraps; v wraps 0 after V_TOTAL-1.
- Output derivation (all outputs registered, updated on tick from the pre-advance (h,v); one tick of latency, all outputs mutually aligned):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines), else ~VS_POL.
  - pix_x = h, pix_y = v.
  - line_start = (h == 0); frame_start = (h == 0 && v == 0).
  - Strobes are high for exactly one clk (the tick cycle), low otherwise.
- Mode latching:
  - mode_q captures mode on the tick where h=0 and v=0; the pattern for the whole frame uses mode_q.
  - A mid-frame change of mode takes effect at the next frame.
  - solid_color is not latched.
- Patterns (active area only; blanking forces colour 0):
  - BARS: bar width = H_ACTIVE/BAR_COUNT (integer); bar index = x/width, saturated at BAR_COUNT-1 (last bar absorbs the remainder); colour = index truncated to COLOR_W.
  - SOLID: colour = solid_color.
  - CHECKER: all bits = x[5] ^ y[5].
  - GRID: all ones when x[4:0]==0, y[4:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; else 0.
- Bar index computation:
  - Uses a running column counter reset at h=0 and incremented at each bar boundary. No divider.
- en = 0:
  - Divider, h and v are held at 0.
  - Outputs are driven to their reset values at the next clk.
  - After en rises, the first tick outputs pixel (0,0) with frame_start.
- Reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - active, line_start, frame_start, color, pix_x, pix_y, mode_q, h, v and divider all = 0.
  - Reset mid-line acts immediately (asynchronously); no partial-line recovery.

Decomposition:
- Package vga_pkg:
  - mode enum: MODE_BARS=0, MODE_SOLID=1, MODE_CHECKER=2, MODE_GRID=3.
  - Default 640x480@60 timing constants.
- Sub-module vga_pattern_gen:
  - Combinational colour from (x, y, mode_q, solid_color, bar index).
  - The top module holds the counters, sync logic and output registers.

Test Plan:
1. Defaults, en=1, mode=BARS -> line_start every 800 clk; hsync low for 96 clk starting when pix_x=656; one frame_start per 420000 clk.
2. BARS -> color=0 at pix_x 0..79, 1 at 80, 7 at 639, 0 at 640 (blanking); vsync low while pix_y is 490..491.
3. mode changed to SOLID (solid_color=5) at pix_y=100 -> bars continue until frame end; color=5 from the next frame_start.
4. CLK_DIV=2 -> line period 1600 clk; strobes one clk wide; outputs change only every second clk.
5. Assert rst_n=0 mid-line at pix_x=300 -> immediately hsync=1, vsync=1, color=0, pix_x=0; after release, the first output is pixel (0,0) with frame_start.
6. H_ACTIVE=10, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, BAR_COUNT=3 -> line of 16 clk; bar widths 3,3,4; frame of 112 clk; en low holds hsync/vsync inactive.
